rc4_phase_sequencer: RTL
========================

RC4_PHASE_SEQUENCER -- requirements
Module: rc4_phase_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, max cycles allowed per phase before error (range 2..65535).
REQ-002 CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to run a full init/shuffle/decrypt sequence with key_in.
REQ-005 key_in  in  24  secret key, sampled only in the cycle start=1.
REQ-006 key_out  out  24  registered copy of the last sampled key, feeding shuffle/decrypt engines.
REQ-007 init_start, shuf_start, dec_start  out  1 each  one-cycle phase start pulses.
REQ-008 init_done, shuf_done, dec_done  in  1 each  one-cycle phase completion pulses.
REQ-009 init_addr/shuf_addr/dec_addr  in  8; init_data/shuf_data/dec_data  in  8; init_wren/shuf_wren/dec_wren  in  1; per-requester S-memory port.
REQ-010 s_addr  out  8; s_data  out  8; s_wren  out  1; shared S-memory port.
REQ-011 abort  out  1  one-cycle pulse telling all engines to return to their idle state.
REQ-012 phase  out  3  current state encoding; busy out 1; done out 1; error out 1.

Function
REQ-013 States and encodings: IDLE=0, INIT=1, SHUFFLE=2, DECRYPT=3, DONE=4, ERROR=5; phase equals the state register.
REQ-014 busy = 1 in INIT, SHUFFLE, DECRYPT; done = 1 only in DONE; error = 1 only in ERROR.
REQ-015 IDLE/DONE/ERROR with start=1: key_out <= key_in; next cycle state=INIT with init_start=1 for that cycle only.
REQ-016 INIT with init_done=1: next cycle state=SHUFFLE, shuf_start=1 for that cycle only.
REQ-017 SHUFFLE with shuf_done=1: next cycle state=DECRYPT, dec_start=1 for that cycle only.
REQ-018 DECRYPT with dec_done=1: next cycle state=DONE; DONE held until start or reset.
REQ-019 Done pulses from a phase other than the current one are ignored.
REQ-020 S-memory mux is combinational, zero latency: INIT selects init_*, SHUFFLE selects shuf_*, DECRYPT selects dec_*; all other states drive s_addr=0, s_data=0, s_wren=0.
REQ-021 At most one *_start asserted per cycle; each *_start is exactly one cycle wide.
REQ-022 start while busy (restart): abort=1 in the next cycle; key_out <= key_in; state=INIT with init_start=1 in that same next cycle; the watchdog is cleared.
REQ-023 start and any *_done in the same cycle: start wins and the done pulse is discarded.
REQ-024 start in IDLE/DONE/ERROR does not pulse abort.
REQ-025 Watchdog: 16-bit counter cleared on every state entry and incremented each cycle in INIT/SHUFFLE/DECRYPT.
REQ-026 Counter reaching TIMEOUT_CYCLES-1 with no matching done: next cycle state=ERROR and abort=1 for one cycle.
REQ-027 Matching done in the same cycle as timeout: done wins and normal advance occurs.
REQ-028 ERROR is held until start (which restarts per REQ-015) or reset.
REQ-029 key_out is stable for the whole sequence and changes only on an accepted start.

Reset
REQ-030 reset_n=0 at a clock edge: state=IDLE; key_out=0; watchdog=0; all *_start, abort, busy, done, error = 0; phase=0.
REQ-031 Reset overrides start, done and timeout in the same cycle; mid-sequence reset returns to IDLE with no abort pulse.

Verification
REQ-032 Nominal: start with key_in=0x000249; init_done after 256 cycles, shuf_done after 768, dec_done after 100 -> phase 1,2,3,4 in order; one pulse each of init_start, shuf_start, dec_start; done=1; key_out=0x000249.
REQ-033 Mux: in SHUFFLE drive shuf_addr=0x3C, shuf_data=0xA5, shuf_wren=1 and init_wren=1 -> s_addr=0x3C, s_data=0xA5, s_wren=1; in IDLE -> s_addr=0, s_data=0, s_wren=0.
REQ-034 Restart: start with key 0x000001, then in SHUFFLE start with key 0x0003FF -> next cycle abort=1, init_start=1, phase=1, key_out=0x0003FF.
REQ-035 Timeout: TIMEOUT_CYCLES=16, withhold init_done -> ERROR (phase=5) with abort=1 exactly 16 cycles after init_start; error stays 1 until start.
REQ-036 Collisions: start together with shuf_done -> restart to INIT; init_done in SHUFFLE -> ignored; done on the timeout cycle -> normal advance, error=0.
REQ-037 Reset: reset_n=0 for one cycle in DECRYPT -> next cycle phase=0, all outputs 0, no abort pulse.

Source files
------------

// File: rtl/rc4_phase_sequencer_if.sv
// Handshake and shared S-memory bundle between the RC4 phase sequencer and its
// init/shuffle/decrypt engines.
interface rc4_phase_sequencer_if;
  logic        start;
  logic [23:0] key_in;
  logic [23:0] key_out;
  logic        init_start, shuf_start, dec_start;
  logic        init_done, shuf_done, dec_done;
  logic [7:0]  init_addr, shuf_addr, dec_addr;
  logic [7:0]  init_data, shuf_data, dec_data;
  logic        init_wren, shuf_wren, dec_wren;
  logic [7:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_wren;
  logic        abort;
  logic [2:0]  phase;
  logic        busy, done, error;

  modport master (
    input  start, key_in,
    input  init_done, shuf_done, dec_done,
    input  init_addr, shuf_addr, dec_addr,
    input  init_data, shuf_data, dec_data,
    input  init_wren, shuf_wren, dec_wren,
    output key_out, init_start, shuf_start, dec_start,
    output s_addr, s_data, s_wren,
    output abort, phase, busy, done, error
  );

  modport slave (
    output start, key_in,
    output init_done, shuf_done, dec_done,
    output init_addr, shuf_addr, dec_addr,
    output init_data, shuf_data, dec_data,
    output init_wren, shuf_wren, dec_wren,
    input  key_out, init_start, shuf_start, dec_start,
    input  s_addr, s_data, s_wren,
    input  abort, phase, busy, done, error
  );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// Sequences RC4 init -> shuffle -> decrypt phases, owns the shared S-memory
// port, and aborts engines on restart or per-phase watchdog timeout.
module rc4_phase_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  rc4_phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHUFFLE = 3'd2,
    DECRYPT = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] key_q, key_d;
  logic [15:0] wdog_q, wdog_d;
  logic        init_start_q, init_start_d;
  logic        shuf_start_q, shuf_start_d;
  logic        dec_start_q, dec_start_d;
  logic        abort_q, abort_d;
  logic        busy;

  assign busy = (state_q == INIT) || (state_q == SHUFFLE) || (state_q == DECRYPT);

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    wdog_d       = busy ? wdog_q + 16'd1 : '0;
    init_start_d = 1'b0;
    shuf_start_d = 1'b0;
    dec_start_d  = 1'b0;
    abort_d      = 1'b0;

    // start takes priority over any done pulse or timeout in the same cycle
    if (bus.start) begin
      key_d        = bus.key_in;
      state_d      = INIT;
      init_start_d = 1'b1;
      abort_d      = busy;
      wdog_d       = '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (bus.init_done) begin
            state_d      = SHUFFLE;
            shuf_start_d = 1'b1;
            wdog_d       = '0;
          end else if (wdog_q == WDOG_LAST) begin
            state_d = ERROR;
            abort_d = 1'b1;
            wdog_d  = '0;
          end
        end
        SHUFFLE: begin
          if (bus.shuf_done) begin
            state_d     = DECRYPT;
            dec_start_d = 1'b1;
            wdog_d      = '0;
          end else if (wdog_q == WDOG_LAST) begin
            state_d = ERROR;
            abort_d = 1'b1;
            wdog_d  = '0;
          end
        end
        DECRYPT: begin
          if (bus.dec_done) begin
            state_d = DONE;
            wdog_d  = '0;
          end else if (wdog_q == WDOG_LAST) begin
            state_d = ERROR;
            abort_d = 1'b1;
            wdog_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      key_q        <= '0;
      wdog_q       <= '0;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      wdog_q       <= wdog_d;
      init_start_q <= init_start_d;
      shuf_start_q <= shuf_start_d;
      dec_start_q  <= dec_start_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    bus.s_addr = '0;
    bus.s_data = '0;
    bus.s_wren = 1'b0;
    unique case (state_q)
      INIT: begin
        bus.s_addr = bus.init_addr;
        bus.s_data = bus.init_data;
        bus.s_wren = bus.init_wren;
      end
      SHUFFLE: begin
        bus.s_addr = bus.shuf_addr;
        bus.s_data = bus.shuf_data;
        bus.s_wren = bus.shuf_wren;
      end
      DECRYPT: begin
        bus.s_addr = bus.dec_addr;
        bus.s_data = bus.dec_data;
        bus.s_wren = bus.dec_wren;
      end
      default: ;
    endcase
  end

  assign bus.key_out    = key_q;
  assign bus.init_start = init_start_q;
  assign bus.shuf_start = shuf_start_q;
  assign bus.dec_start  = dec_start_q;
  assign bus.abort      = abort_q;
  assign bus.phase      = state_q;
  assign bus.busy       = busy;
  assign bus.done       = (state_q == DONE);
  assign bus.error      = (state_q == ERROR);

endmodule
